// File: rtl/dp_exec_seq.sv
// Execute/writeback sequencer for the 8x16 register file: reads Rn then Rm, shifts B, runs the ALU, writes Rd.
// Optional DP_FULL_STATUS_EN widens status from {Z} to {V,N,Z}.
module dp_exec_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [1:0]   shift,
    input  logic [2:0]   rn,
    input  logic [2:0]   rm,
    input  logic [2:0]   rd,
    input  logic [W-1:0] rf_data_out,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic [W-1:0] wb_data,
    output logic         busy,
    output logic         done,
`ifdef DP_FULL_STATUS_EN
    output logic [2:0]   status
`else
    output logic [0:0]   status
`endif
);

`ifdef DP_FULL_STATUS_EN
    localparam int S = 3;
`else
    localparam int S = 1;
`endif

    // state | meaning
    // IDLE  | waiting for start; operands latched on acceptance
    // RDA   | readnum = rn, A captured at edge
    // RDB   | readnum = rm, B captured at edge
    // EXEC  | shift B, ALU, latch C and status
    // WB    | write C to rd, done pulse
    typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

    state_t         state;
    logic [W-1:0]   a, b, c;
    logic [1:0]     op_l, shift_l;
    logic [2:0]     rm_l, rd_l;
    logic [W-1:0]   bs, r;
    logic [S-1:0]   flags;

    assign wb_data = c;

    always_comb begin
        bs = b;
        case (shift_l)
            2'b01:   bs = {b[W-2:0], 1'b0};
            2'b10:   bs = {1'b0, b[W-1:1]};
            2'b11:   bs = {b[W-1], b[W-1:1]};
            default: bs = b;
        endcase

        r = '0;
        case (op_l)
            2'b00:   r = a + bs;
            2'b01:   r = a - bs;
            2'b10:   r = a & bs;
            default: r = ~bs;
        endcase

`ifdef DP_FULL_STATUS_EN
        flags = {1'b0, r[W-1], (r == '0)};
        if (op_l == 2'b00)
            flags[2] = (a[W-1] == bs[W-1]) && (r[W-1] != a[W-1]);
        else if (op_l == 2'b01)
            flags[2] = (a[W-1] != bs[W-1]) && (r[W-1] != a[W-1]);
`else
        flags = (r == '0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            status   <= '0;
            op_l     <= '0;
            shift_l  <= '0;
            rm_l     <= '0;
            rd_l     <= '0;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_l    <= op;
                        shift_l <= shift;
                        rm_l    <= rm;
                        rd_l    <= rd;
                        readnum <= rn;
                        busy    <= 1'b1;
                        state   <= RDA;
                    end
                end
                RDA: begin
                    a       <= rf_data_out;
                    readnum <= rm_l;
                    state   <= RDB;
                end
                RDB: begin
                    b       <= rf_data_out;
                    readnum <= '0;
                    state   <= EXEC;
                end
                EXEC: begin
                    c        <= r;
                    status   <= flags;
                    writenum <= rd_l;
                    write    <= 1'b1;
                    done     <= 1'b1;
                    state    <= WB;
                end
                default: begin
                    writenum <= '0;
                    write    <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_exec_seq.sv
// Self-checking bench for dp_exec_seq with a behavioural register file and arithmetic reference model.
module tb_dp_exec_seq;

`ifdef DP_FULL_STATUS_EN
    localparam int S = 3;
`else
    localparam int S = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = '0, shift = '0;
    logic [2:0]   rn = '0, rm = '0, rd = '0;
    logic [15:0]  rf_data_out;
    logic [2:0]   readnum, writenum;
    logic         write, busy, done;
    logic [15:0]  wb_data;
    logic [S-1:0] status;

    logic [15:0]  regs [8];
    logic         pl_en = 1'b0;
    logic [2:0]   pl_idx = '0;
    logic [15:0]  pl_val = '0;
    int           wr_cnt = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    dp_exec_seq #(.W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .shift(shift),
        .rn(rn), .rm(rm), .rd(rd), .rf_data_out(rf_data_out),
        .readnum(readnum), .writenum(writenum), .write(write),
        .wb_data(wb_data), .busy(busy), .done(done), .status(status)
    );

    assign rf_data_out = regs[readnum];

    always @(posedge clk) begin
        if (pl_en) regs[pl_idx] <= pl_val;
        else if (write) begin
            regs[writenum] <= wb_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic int sgn(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference: shift/ALU/flags derived from plain integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [1:0] sh, input int av, input int bv,
                         output logic [15:0] res, output logic [S-1:0] st);
        int bsv, rv, ex;
        logic v;
        case (sh)
            2'd1:    bsv = (bv * 2) % 65536;
            2'd2:    bsv = bv / 2;
            2'd3:    bsv = (bv / 2) + ((bv >= 32768) ? 32768 : 0);
            default: bsv = bv;
        endcase
        v = 1'b0;
        case (o)
            2'd0: begin rv = (av + bsv) % 65536; ex = sgn(av) + sgn(bsv); v = (ex > 32767) || (ex < -32768); end
            2'd1: begin rv = (av - bsv + 65536) % 65536; ex = sgn(av) - sgn(bsv); v = (ex > 32767) || (ex < -32768); end
            2'd2: rv = av & bsv;
            default: rv = 65535 - bsv;
        endcase
        res = rv[15:0];
`ifdef DP_FULL_STATUS_EN
        st = {v, (rv >= 32768), (rv == 0)};
`else
        st = (rv == 0);
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
    task automatic run_op(input logic [1:0] o, input logic [1:0] sh, input logic [2:0] n,
                          input logic [2:0] m, input logic [2:0] d, input bit glitch, input bit abort);
        logic [15:0] er, old_d;
        logic [S-1:0] es;
        int wc0;
        model(o, sh, int'(regs[n]), int'(regs[m]), er, es);
        old_d = regs[d];
        wc0 = wr_cnt;
        start = 1'b1; op = o; shift = sh; rn = n; rm = m; rd = d;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); shift = 2'($urandom);
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
        chk("rda_readnum", 32'(readnum), 32'(n));
        chk("rda_busy", 32'(busy), 1);
        @(negedge clk);
        chk("rdb_readnum", 32'(readnum), 32'(m));
        chk("rdb_busy", 32'(busy), 1);
        if (glitch) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("exec_busy", 32'(busy), 1);
        chk("exec_write", 32'(write), 0);
        if (abort) begin
            #2 reset = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_write", 32'(write), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_c", 32'(wb_data), 0);
            chk("abort_status", 32'(status), 0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            chk("abort_idle", 32'(busy), 0);
            chk("abort_no_write", 32'(wr_cnt), 32'(wc0));
            chk("abort_rd_kept", 32'(regs[d]), 32'(old_d));
            return;
        end
        @(negedge clk);
        chk("wb_write", 32'(write), 1);
        chk("wb_done", 32'(done), 1);
        chk("wb_busy", 32'(busy), 1);
        chk("wb_writenum", 32'(writenum), 32'(d));
        chk("wb_data", 32'(wb_data), 32'(er));
        chk("wb_status", 32'(status), 32'(es));
        if (glitch) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("rd_value", 32'(regs[d]), 32'(er));
        chk("write_count", 32'(wr_cnt), 32'(wc0 + 1));
        chk("c_hold", 32'(wb_data), 32'(er));
        chk("status_hold", 32'(status), 32'(es));
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_readnum", 32'(readnum), 0);
        chk("rst_writenum", 32'(writenum), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_status", 32'(status), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) preload(3'(i), 16'(i * 16'h1111));

        preload(3'd1, 16'h0007);
        preload(3'd2, 16'h0003);
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
        chk("add_r3", 32'(regs[3]), 32'h000A);

        run_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("sub_r1_zero", 32'(regs[1]), 0);
        chk("sub_z", 32'(status[0]), 1);

        preload(3'd2, 16'h8001);
        run_op(2'b11, 2'b11, 3'd0, 3'd2, 3'd4, 1'b0, 1'b0);
        chk("mvn_asr", 32'(regs[4]), 32'h3FFF);
        run_op(2'b11, 2'b10, 3'd0, 3'd2, 3'd4, 1'b0, 1'b0);
        chk("mvn_lsr", 32'(regs[4]), 32'hBFFF);
        run_op(2'b11, 2'b01, 3'd0, 3'd2, 3'd4, 1'b0, 1'b0);
        chk("mvn_lsl", 32'(regs[4]), 32'hFFFD);

        preload(3'd5, 16'h7FFF);
        preload(3'd6, 16'h0001);
        run_op(2'b00, 2'b00, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0);
        chk("ovf_add", 32'(regs[7]), 32'h8000);
        preload(3'd5, 16'h8000);
        run_op(2'b01, 2'b00, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0);
        chk("ovf_sub", 32'(regs[7]), 32'h7FFF);

        // Ignored starts in RDB/WB, then an immediate back-to-back accept.
        run_op(2'b00, 2'b00, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
        run_op(2'b10, 2'b00, 3'd2, 3'd4, 3'd5, 1'b0, 1'b0);

        preload(3'd1, 16'h1234);
        run_op(2'b00, 2'b00, 3'd1, 3'd1, 3'd6, 1'b0, 1'b1);
        run_op(2'b00, 2'b00, 3'd1, 3'd1, 3'd6, 1'b0, 1'b0);
        chk("post_abort_add", 32'(regs[6]), 32'h2468);

        for (int k = 0; k < 30; k++) begin
            if (k % 4 == 0) preload(3'($urandom), 16'($urandom));
            run_op(2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   1'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
